// File: rtl/rvga_types.sv
// ============================================================================
// rvga_types : shared word/byte-enable types and memory-arbiter state encoding
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rvga_types;

    typedef logic [31:0] rvga_word;
    typedef logic [3:0]  rvga_be;

    localparam rvga_be RVGA_BE_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_ISSUE = 3'd1,
        IF_WAIT  = 3'd2,
        DM_ISSUE = 3'd3,
        DM_WAIT  = 3'd4
    } memarb_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_ctl.sv
// ============================================================================
// mem_arbiter_ctl : transaction FSM, fetch-squash flag and data-streak counter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_ctl
    import rvga_types::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_v_i,
    input  logic if_flush_i,
    input  logic dm_req_v_i,
    input  logic mem_ready_i,
    input  logic mem_rvalid_i,
    output logic grant_if_o,
    output logic grant_dm_o,
    output logic mem_req_v_o,
    output logic if_load_o,
    output logic dm_load_o,
    output logic if_done_o,
    output logic dm_done_o
);

    localparam logic [3:0] c_MAX_DS = 4'(MAX_DSTREAK);

    memarb_state_e state_q, state_d;
    logic          sq_q, sq_d;
    logic [3:0]    ds_q, ds_d;
    logic          if_done_q, dm_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sq_q      <= 1'b0;
            ds_q      <= 4'd0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sq_q      <= sq_d;
            ds_q      <= ds_d;
            if_done_q <= if_load_o;
            dm_done_q <= dm_load_o;
        end
    end

    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        ds_d        = ds_q;
        grant_if_o  = 1'b0;
        grant_dm_o  = 1'b0;
        mem_req_v_o = 1'b0;
        if_load_o   = 1'b0;
        dm_load_o   = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins unless fetch has already waited out a full streak.
                if (dm_req_v_i && !(if_req_v_i && (ds_q == c_MAX_DS))) begin
                    state_d    = DM_ISSUE;
                    grant_dm_o = 1'b1;
                    ds_d       = if_req_v_i ? sat_inc4(ds_q) : 4'd0;
                end else if (if_req_v_i && !if_flush_i) begin
                    state_d    = IF_ISSUE;
                    grant_if_o = 1'b1;
                    ds_d       = 4'd0;
                end
            end
            IF_ISSUE: begin
                mem_req_v_o = 1'b1;
                if (if_flush_i) sq_d = 1'b1;
                if (mem_ready_i) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (if_flush_i) sq_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d   = IDLE;
                    sq_d      = 1'b0;
                    if_load_o = !sq_q && !if_flush_i;
                end
            end
            DM_ISSUE: begin
                mem_req_v_o = 1'b1;
                if (mem_ready_i) state_d = DM_WAIT;
            end
            DM_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d   = IDLE;
                    dm_load_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_done_o = if_done_q;
    assign dm_done_o = dm_done_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between instruction fetch and data
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import rvga_types::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     if_req_v_i,
    input  rvga_word if_addr_i,
    input  logic     if_flush_i,
    output rvga_word if_data_o,
    output logic     if_done_o,
    input  logic     dm_req_v_i,
    input  logic     dm_we_i,
    input  rvga_be   dm_be_i,
    input  rvga_word dm_addr_i,
    input  rvga_word dm_wdata_i,
    output rvga_word dm_rdata_o,
    output logic     dm_done_o,
    output logic     mem_req_v_o,
    input  logic     mem_ready_i,
    output logic     mem_we_o,
    output rvga_be   mem_be_o,
    output rvga_word mem_addr_o,
    output rvga_word mem_wdata_o,
    input  logic     mem_rvalid_i,
    input  rvga_word mem_rdata_i
);

    logic w_grant_if, w_grant_dm, w_if_load, w_dm_load;

    logic     req_we_q;
    rvga_be   req_be_q;
    rvga_word req_addr_q, req_wdata_q;
    rvga_word if_data_q, dm_rdata_q;

    mem_arbiter_ctl #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_ctl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .if_req_v_i   (if_req_v_i),
        .if_flush_i   (if_flush_i),
        .dm_req_v_i   (dm_req_v_i),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .grant_if_o   (w_grant_if),
        .grant_dm_o   (w_grant_dm),
        .mem_req_v_o  (mem_req_v_o),
        .if_load_o    (w_if_load),
        .dm_load_o    (w_dm_load),
        .if_done_o    (if_done_o),
        .dm_done_o    (dm_done_o)
    );

    // The winner's fields are captured at grant so mem_* stay stable while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (w_grant_dm) begin
                req_we_q    <= dm_we_i;
                req_be_q    <= dm_be_i;
                req_addr_q  <= dm_addr_i;
                req_wdata_q <= dm_wdata_i;
            end else if (w_grant_if) begin
                req_we_q    <= 1'b0;
                req_be_q    <= RVGA_BE_FULL;
                req_addr_q  <= if_addr_i;
                req_wdata_q <= '0;
            end
            if (w_if_load) if_data_q  <= mem_rdata_i;
            if (w_dm_load) dm_rdata_q <= mem_rdata_i;
        end
    end

    assign mem_we_o    = req_we_q;
    assign mem_be_o    = req_be_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : self-checking bench with a behavioural memory and requesters
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int MAXDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        dm_req, dm_we, dm_done;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req_v, mem_ready, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } hs_t;

    hs_t         hs_log[$];
    logic [31:0] dev_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit          rand_mem = 1'b0;
    int          cfg_stall = 0, cfg_rvd = 1, stall_left = 0, cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] resp;
    int          overlap_errs = 0, dbl_done_errs = 0;
    int          if_done_cnt = 0, dm_done_cnt = 0;
    bit          prev_if = 1'b0, prev_dm = 1'b0;

    mem_arbiter #(.MAX_DSTREAK(MAXDS)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_v_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_data_o(if_data), .if_done_o(if_done),
        .dm_req_v_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be),
        .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_done_o(dm_done),
        .mem_req_v_o(mem_req_v), .mem_ready_i(mem_ready),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory device: optional ready stall per request, response rvd cycles after accept.
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = resp; pend = 1'b0;
                end else cnt--;
            end
            mem_ready = 1'b0;
            if (mem_req_v === 1'b1 && !rst) begin
                if (pend || mem_rvalid) overlap_errs++;
                if (stall_left > 0) stall_left--;
                else begin
                    mem_ready = 1'b1;
                    hs_log.push_back('{mem_we, mem_be, mem_addr, mem_wdata});
                    if (mem_we) begin
                        dev_mem[mem_addr] = merge(dev_read(mem_addr), mem_wdata, mem_be);
                        resp = 32'h0;
                    end else resp = dev_read(mem_addr);
                    pend = 1'b1;
                    cnt  = (rand_mem ? $urandom_range(1, 3) : cfg_rvd) - 1;
                    stall_left = rand_mem ? $urandom_range(0, 2) : cfg_stall;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (if_done === 1'b1) begin if_done_cnt++; if (prev_if) dbl_done_errs++; end
            if (dm_done === 1'b1) begin dm_done_cnt++; if (prev_dm) dbl_done_errs++; end
            prev_if = (if_done === 1'b1);
            prev_dm = (dm_done === 1'b1);
        end
    end

    task automatic set_mem(input int stall, input int rvd);
        cfg_stall = stall; cfg_rvd = rvd; stall_left = stall;
    endtask

    task automatic test_reset;
        rst = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({mem_req_v, if_done, dm_done, mem_we} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {mem_req_v, if_done, dm_done, mem_we}); end
        n_checks++; if ({mem_be, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_req: got %h want 0", {mem_be, mem_addr, mem_wdata}); end
        n_checks++; if ({if_data, dm_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {if_data, dm_rdata}); end
        rst = 1'b0;
    endtask

    task automatic test_fetch_basic;
        dev_mem[32'h100] = 32'h0000_0013; set_mem(0, 1);
        @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        n_checks++; if ({mem_req_v, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            n_fail++; $display("FAIL fetch_issue: got v=%b we=%b be=%h a=%h want 1 0 f 100",
                               mem_req_v, mem_we, mem_be, mem_addr); end
        @(negedge clk);
        n_checks++; if ({mem_req_v, if_done} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_wait: got v=%b done=%b want 0 0", mem_req_v, if_done); end
        @(negedge clk);
        n_checks++; if (if_done !== 1'b1 || if_data !== 32'h13) begin
            n_fail++; $display("FAIL fetch_done: got done=%b data=%h want 1 00000013", if_done, if_data); end
        if_req = 1'b0;
        @(negedge clk);
        n_checks++; if (if_done !== 1'b0 || if_data !== 32'h13 || mem_req_v !== 1'b0) begin
            n_fail++; $display("FAIL fetch_after: got done=%b data=%h v=%b want 0 00000013 0",
                               if_done, if_data, mem_req_v); end
    endtask

    task automatic test_priority;
        int t_dm = -1, t_if = -1;
        logic [31:0] got_dm = '0, got_if = '0;
        set_mem(0, 1); hs_log.delete(); overlap_errs = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = '0;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (dm_done === 1'b1) begin t_dm = cyc; got_dm = dm_rdata; dm_req = 1'b0; break; end
                end
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (if_done === 1'b1) begin t_if = cyc; got_if = if_data; if_req = 1'b0; break; end
                end
            end
        join
        dm_req = 1'b0; if_req = 1'b0;
        n_checks++; if (t_dm < 0 || t_if < 0) begin
            n_fail++; $display("FAIL prio_timeout: got t_dm=%0d t_if=%0d want both done", t_dm, t_if); end
        n_checks++; if (t_if - t_dm !== 3) begin
            n_fail++; $display("FAIL prio_order: got if-dm gap %0d want 3", t_if - t_dm); end
        n_checks++; if (hs_log.size() != 2 || hs_log[0].addr !== 32'h2000 || hs_log[1].addr !== 32'h300) begin
            n_fail++; $display("FAIL prio_bus: got %0d handshakes want 2 (2000 then 300)", hs_log.size()); end
        n_checks++; if (got_dm !== init_word(32'h2000) || got_if !== init_word(32'h300)) begin
            n_fail++; $display("FAIL prio_data: got %h/%h want %h/%h", got_dm, got_if,
                               init_word(32'h2000), init_word(32'h300)); end
        n_checks++; if (overlap_errs != 0) begin
            n_fail++; $display("FAIL prio_overlap: got %0d want 0", overlap_errs); end
    endtask

    task automatic test_streak;
        int n = 0;
        bit exp_f, got_f;
        set_mem(0, 1); hs_log.delete();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h2000;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dm_done === 1'b1 || if_done === 1'b1) n++;
            if (n == 3 * (MAXDS + 1)) break;
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (n != 3 * (MAXDS + 1) || hs_log.size() != 3 * (MAXDS + 1)) begin
            n_fail++; $display("FAIL streak_count: got %0d done %0d hs want %0d", n, hs_log.size(),
                               3 * (MAXDS + 1)); end
        for (int i = 0; i < hs_log.size(); i++) begin
            exp_f = ((i % (MAXDS + 1)) == MAXDS);
            got_f = (hs_log[i].addr == 32'h400);
            n_checks++; if (got_f !== exp_f) begin
                n_fail++; $display("FAIL streak_pat[%0d]: got fetch=%b want %b", i, got_f, exp_f); end
        end
    endtask

    task automatic test_flush;
        int seen = 0, ok = 0;
        // Flush in wait cycle 2 while the response is still 3 cycles away.
        set_mem(0, 5); hs_log.delete(); pend = pend;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h500;
        repeat (3) @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk); if_flush = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (if_done === 1'b1) seen++; end
        n_checks++; if (seen != 0 || hs_log.size() != 1 || pend) begin
            n_fail++; $display("FAIL flush_wait: got done=%0d hs=%0d pend=%b want 0 1 0", seen, hs_log.size(), pend); end
        // Flush in the same cycle as the response.
        set_mem(0, 2);
        @(negedge clk); if_req = 1'b1; if_addr = 32'h540;
        repeat (3) @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk); if_flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (if_done === 1'b1) seen++; end
        n_checks++; if (seen != 0 || if_data === init_word(32'h540)) begin
            n_fail++; $display("FAIL flush_rvalid: got done=%0d data=%h want no done", seen, if_data); end
        // Flush alongside a fresh request in IDLE blocks that cycle's grant.
        set_mem(0, 1);
        @(negedge clk); if_req = 1'b1; if_addr = 32'h200; if_flush = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req_v !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got v=%b want 0", mem_req_v); end
        if_flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_done === 1'b1) begin ok = 1; if_req = 1'b0; break; end
        end
        if_req = 1'b0;
        n_checks++; if (!ok || if_data !== init_word(32'h200) || hs_log[hs_log.size()-1].addr !== 32'h200) begin
            n_fail++; $display("FAIL flush_refetch: got ok=%0d data=%h want 1 %h", ok, if_data, init_word(32'h200)); end
    endtask

    task automatic test_store_stall;
        logic [31:0] exp_w;
        int ok = 0;
        set_mem(3, 1);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({mem_req_v, mem_we, mem_be, mem_addr, mem_wdata} !==
                            {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF}) begin
                n_fail++; $display("FAIL store_hold[%0d]: got v=%b we=%b be=%h a=%h d=%h", k,
                                   mem_req_v, mem_we, mem_be, mem_addr, mem_wdata); end
        end
        @(negedge clk);
        n_checks++; if (mem_req_v !== 1'b0 || dm_done !== 1'b0) begin
            n_fail++; $display("FAIL store_wait: got v=%b done=%b want 0 0", mem_req_v, dm_done); end
        @(negedge clk);
        n_checks++; if (dm_done !== 1'b1) begin
            n_fail++; $display("FAIL store_done: got %b want 1", dm_done); end
        dm_req = 1'b0;
        exp_w = merge(init_word(32'h40), 32'hDEADBEEF, 4'b0011);
        ref_mem[32'h40] = exp_w;
        set_mem(0, 1);
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dm_done === 1'b1) begin ok = 1; dm_req = 1'b0; break; end
        end
        dm_req = 1'b0;
        n_checks++; if (!ok || dm_rdata !== exp_w) begin
            n_fail++; $display("FAIL store_readback: got %h want %h", dm_rdata, exp_w); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        set_mem(0, 6);
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h3000;
        repeat (2) @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({mem_req_v, dm_done, if_done} !== 3'b000 || {dm_rdata, if_data, mem_addr, mem_be} !== '0) begin
            n_fail++; $display("FAIL rstmid_out: got v=%b d=%b a=%h rd=%h want all 0", mem_req_v, dm_done,
                               mem_addr, dm_rdata); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (dm_done === 1'b1 || mem_req_v === 1'b1) seen++; end
        n_checks++; if (seen != 0 || dm_rdata !== 32'h0 || pend) begin
            n_fail++; $display("FAIL rstmid_late: got act=%0d rd=%h pend=%b want 0 0 0", seen, dm_rdata, pend); end
    endtask

    task automatic test_random;
        rand_mem = 1'b1; stall_left = 0;
        fork
            begin
                logic [31:0] a, exp;
                int ok, dm_seen;
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = 32'h1000 + 4 * $urandom_range(0, 31);
                    if_req = 1'b1; if_addr = a; ok = 0; dm_seen = 0;
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk);
                        if (dm_done === 1'b1) dm_seen++;
                        if (if_done === 1'b1) begin ok = 1; exp = init_word(a);
                            n_checks++; if (if_data !== exp) begin
                                n_fail++; $display("FAIL rnd_fetch: got %h want %h @%h", if_data, exp, a); end
                            break;
                        end
                    end
                    if_req = 1'b0;
                    n_checks++; if (!ok || dm_seen > MAXDS + 1) begin
                        n_fail++; $display("FAIL rnd_fetch_fair: got done=%0d data_grants=%0d want 1 <=%0d",
                                           ok, dm_seen, MAXDS + 1); end
                end
            end
            begin
                logic [31:0] a, w, exp;
                logic [3:0]  be;
                logic        we;
                int ok;
                for (int t = 0; t < 60; t++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = 32'h8000 + 4 * $urandom_range(0, 15);
                    we = 1'($urandom_range(0, 1)); be = 4'($urandom_range(1, 15)); w = $urandom;
                    dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = a; dm_wdata = w; ok = 0;
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk);
                        if (dm_done === 1'b1) begin ok = 1; break; end
                    end
                    dm_req = 1'b0;
                    if (ok && we) ref_mem[a] = merge(ref_read(a), w, be);
                    exp = ref_read(a);
                    n_checks++; if (!ok || (!we && dm_rdata !== exp)) begin
                        n_fail++; $display("FAIL rnd_data: got done=%0d rd=%h want 1 %h @%h", ok, dm_rdata, exp, a); end
                end
            end
        join
        rand_mem = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (overlap_errs != 0 || dbl_done_errs != 0) begin
            n_fail++; $display("FAIL rnd_protocol: got overlap=%0d dbl_done=%0d want 0 0", overlap_errs, dbl_done_errs); end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_priority();
        test_streak();
        test_flush();
        test_store_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
